// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle logic/add/sub/slt, iterative unsigned
// multiply/divide into HI/LO with a start/busy/done handshake.
module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       Operation,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic             Overflow,
    output logic             Busy,
    output logic             Done,
    output logic [1:0]       dbg_state
);
    // Handshake: start/Operation/A/B are taken on a rising edge only while Busy=0;
    // Done is a one-cycle pulse per accepted op; start during Busy is dropped.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_NOR   = 4'b1100;
    localparam logic [3:0] OP_MULTU = 4'b1000;
    localparam logic [3:0] OP_DIVU  = 4'b1001;
    localparam logic [3:0] OP_MFHI  = 4'b1010;
    localparam logic [3:0] OP_MFLO  = 4'b1011;

    typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2} state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   divisor;

    logic [WIDTH-1:0]   sum;
    logic [WIDTH-1:0]   diff;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_ovf;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] prod_next;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     trial;
    logic [WIDTH-1:0]   rem_next;
    logic [WIDTH-1:0]   quot_next;

    assign dbg_state = state;

    always_comb begin
        sum     = A + B;
        diff    = A - B;
        alu_res = '0;
        alu_ovf = 1'b0;
        case (Operation)
            OP_AND:  alu_res = A & B;
            OP_OR:   alu_res = A | B;
            OP_NOR:  alu_res = ~(A | B);
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
            end
            // Direct signed compare so a wrapped difference cannot flip the answer.
            OP_SLT:  alu_res = ($signed(A) < $signed(B)) ? WIDTH'(1) : '0;
            OP_MFHI: alu_res = hi;
            OP_MFLO: alu_res = lo;
            default: alu_res = '0;
        endcase
    end

    // Shift-add: upper half accumulates, product shifts right one bit per cycle.
    always_comb begin
        mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} +
                    (prod[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
        prod_next = {mul_sum, prod[WIDTH-1:1]};
    end

    // Restoring divide; a zero divisor always "fits", giving all-ones / dividend.
    always_comb begin
        shifted = {rem, quot[WIDTH-1]};
        trial   = shifted - {1'b0, divisor};
        if (!trial[WIDTH]) begin
            rem_next  = trial[WIDTH-1:0];
            quot_next = {quot[WIDTH-2:0], 1'b1};
        end else begin
            rem_next  = shifted[WIDTH-1:0];
            quot_next = {quot[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            hi       <= '0;
            lo       <= '0;
            prod     <= '0;
            mcand    <= '0;
            rem      <= '0;
            quot     <= '0;
            divisor  <= '0;
            Result   <= '0;
            Zero     <= 1'b1;
            Overflow <= 1'b0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (Operation == OP_MULTU) begin
                            mcand <= A;
                            prod  <= {{WIDTH{1'b0}}, B};
                            cnt   <= '0;
                            Busy  <= 1'b1;
                            state <= MUL;
                        end else if (Operation == OP_DIVU) begin
                            divisor <= B;
                            quot    <= A;
                            rem     <= '0;
                            cnt     <= '0;
                            Busy    <= 1'b1;
                            state   <= DIV;
                        end else begin
                            Result   <= alu_res;
                            Zero     <= (alu_res == '0);
                            Overflow <= alu_ovf;
                            Done     <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    prod <= prod_next;
                    cnt  <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        hi    <= prod_next[2*WIDTH-1:WIDTH];
                        lo    <= prod_next[WIDTH-1:0];
                        Done  <= 1'b1;
                        Busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                DIV: begin
                    rem  <= rem_next;
                    quot <= quot_next;
                    cnt  <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        hi    <= rem_next;
                        lo    <= quot_next;
                        Done  <= 1'b1;
                        Busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboarded bench for alu_exec_unit: expected {Overflow,Zero,Result} queued
// at issue time and compared on every Done pulse.
module tb_alu_exec_unit;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [3:0]   operation;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic [W-1:0] result;
    logic         zero;
    logic         overflow;
    logic         busy;
    logic         done;
    logic [1:0]   dbg_state;

    alu_exec_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .Operation(operation),
        .A(a_in), .B(b_in), .Result(result), .Zero(zero),
        .Overflow(overflow), .Busy(busy), .Done(done), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [W+1:0] exp_q[$];

    logic [W-1:0] m_hi  = '0;
    logic [W-1:0] m_lo  = '0;
    logic [W-1:0] m_res = '0;
    logic         m_zero = 1'b1;
    logic         m_ovf  = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference model written from the op table, using exact signed arithmetic.
    task automatic model_single(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint s;
        m_ovf = 1'b0;
        case (op)
            4'b0000: m_res = a & b;
            4'b0001: m_res = a | b;
            4'b1100: m_res = ~(a | b);
            4'b0010: begin
                s = sa + sb;
                m_res = W'(s);
                m_ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'b0110: begin
                s = sa - sb;
                m_res = W'(s);
                m_ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'b0111: m_res = (sa < sb) ? W'(1) : W'(0);
            4'b1010: m_res = m_hi;
            4'b1011: m_res = m_lo;
            default: m_res = '0;
        endcase
        m_zero = (m_res == '0);
    endtask

    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        model_single(op, a, b);
        exp_q.push_back({m_ovf, m_zero, m_res});
        start = 1'b1; operation = op; a_in = a; b_in = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic issue_long(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                              input bit poke);
        int cyc;
        logic [63:0] p;
        exp_q.push_back({m_ovf, m_zero, m_res});
        if (op == 4'b1000) begin
            p = 64'(a) * 64'(b);
            m_hi = p[63:32];
            m_lo = p[31:0];
        end else if (b == '0) begin
            m_lo = '1;
            m_hi = a;
        end else begin
            m_lo = a / b;
            m_hi = a % b;
        end
        start = 1'b1; operation = op; a_in = a; b_in = b;
        @(negedge clk);
        start = 1'b0;
        check("busy_start", 64'(busy), 64'd1);
        cyc = 0;
        while (!done && cyc < 4 * W) begin
            if (poke && cyc == 5) begin
                start = 1'b1; operation = 4'b0010; a_in = 1; b_in = 1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
            if (cyc == W / 2) check("busy_mid", 64'(busy), 64'd1);
        end
        start = 1'b0;
        check("long_latency", 64'(cyc), 64'(W));
        check("busy_end", 64'(busy), 64'd0);
    endtask

    always @(negedge clk) begin
        logic [W+1:0] e;
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("result", 64'(result), 64'(e[W-1:0]));
                check("zero", 64'(zero), 64'(e[W]));
                check("overflow", 64'(overflow), 64'(e[W+1]));
            end
        end
    end

    initial begin
        logic [3:0] ops[10];
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111,
                4'b1100, 4'b0101, 4'b1010, 4'b1011, 4'b1111};
        rst = 1'b1; start = 1'b0; operation = '0; a_in = '0; b_in = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_result", 64'(result), 64'd0);
        check("rst_zero", 64'(zero), 64'd1);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);

        issue(4'b0010, 32'h7FFF_FFFF, 32'h1);
        check("add_done_latency", 64'(done), 64'd1);
        @(negedge clk);
        check("done_drops", 64'(done), 64'd0);
        issue(4'b0110, 32'd5, 32'd5);
        issue(4'b0111, 32'hFFFF_FFFF, 32'd1);
        issue(4'b1100, 32'h0, 32'h0);
        issue(4'b0110, 32'h8000_0000, 32'h1);
        issue(4'b0111, 32'h8000_0000, 32'h7FFF_FFFF);
        issue(4'b0111, 32'h7FFF_FFFF, 32'h8000_0000);

        issue_long(4'b1000, 32'hFFFF_FFFF, 32'd2, 1'b1);
        issue(4'b1010, '0, '0);
        issue(4'b1011, '0, '0);
        issue_long(4'b1001, 32'd100, 32'd7, 1'b0);
        issue(4'b1011, '0, '0);
        issue(4'b1010, '0, '0);
        issue_long(4'b1001, 32'd9, 32'd0, 1'b0);
        issue(4'b1011, '0, '0);
        issue(4'b1010, '0, '0);

        issue(4'b0101, 32'h1234, 32'h5678);
        issue(4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00);
        issue(4'b0001, 32'hF0F0_F0F0, 32'h0F0F_0000);
        check("b2b_done_held", 64'(done), 64'd1);

        for (int i = 0; i < 24; i++) begin
            ra = (i % 4 == 0) ? 32'h8000_0000 : W'($urandom);
            rb = (i % 5 == 0) ? 32'h7FFF_FFFF : W'($urandom);
            if (i % 8 == 7) issue_long($urandom_range(0, 1) ? 4'b1000 : 4'b1001, ra, rb >> $urandom_range(0, 31), 1'b0);
            else issue(ops[$urandom_range(0, 9)], ra, rb);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end

        issue_long(4'b1000, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
        start = 1'b1; operation = 4'b1000; a_in = 32'hFFFF; b_in = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_hi = '0; m_lo = '0; m_res = '0; m_zero = 1'b1; m_ovf = 1'b0;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_result", 64'(result), 64'd0);
        repeat (W + 4) @(negedge clk);
        issue(4'b1011, '0, '0);
        issue(4'b1010, '0, '0);

        repeat (4) @(negedge clk);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Execute-stage ALU that consumes the 4-bit `Operation` code produced by the ALU control decoder and computes the result for the datapath. Logic ops, add/sub and set-less-than complete in one registered cycle. Unsigned multiply and divide run iteratively into internal HI/LO registers under a start/busy/done handshake, which the control path uses to stall.

## Interface
Parameters:
- `WIDTH`, 32, operand/result width; multiply/divide iteration count equals `WIDTH`.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  request; sampled only when `Busy`=0.
- `Operation`  in  4  op code, sampled with `start`.
- `A`  in  WIDTH  operand rs, sampled with `start`.
- `B`  in  WIDTH  operand rt, sampled with `start`.
- `Result`  out  WIDTH  registered result.
- `Zero`  out  1  registered; 1 when `Result`==0.
- `Overflow`  out  1  registered signed overflow, ADD/SUB only.
- `Busy`  out  1  high while a multiply/divide iterates.
- `Done`  out  1  one-cycle pulse when an accepted op completes.

## Operation
- Op codes:
  - 0000 AND.
  - 0001 OR.
  - 0010 ADD.
  - 0110 SUB.
  - 0111 SLT: signed compare, result 1 or 0.
  - 1100 NOR.
  - 1000 MULTU: {HI,LO} = A*B unsigned.
  - 1001 DIVU: LO = A/B, HI = A%B unsigned.
  - 1010 MFHI: Result = HI.
  - 1011 MFLO: Result = LO.
  - All other codes: Result = 0.
- States: IDLE, MUL, DIV.
- IDLE:
  - Accept when `start`=1.
  - Single-cycle ops (everything except 1000/1001) write `Result`/`Zero`/`Overflow` and pulse `Done` on the accepting edge; the state stays IDLE.
  - 1000 latches operands and clears the iteration counter, then goes to MUL.
  - 1001 latches operands and clears the iteration counter, then goes to DIV.
- MUL: shift-add, one multiplier bit per cycle, `WIDTH` cycles. On the last cycle HI/LO are written, `Done` pulses, and the state returns to IDLE.
- DIV: restoring division, one quotient bit per cycle, `WIDTH` cycles. On the last cycle HI/LO are written, `Done` pulses, and the state returns to IDLE.
- MULTU/DIVU leave `Result`, `Zero` and `Overflow` unchanged. Software reads the product or quotient with MFHI/MFLO.
- Divide by zero: no trap; the algorithm yields LO = all ones and HI = A.
- `Overflow`: ADD is set when both operand signs are equal and the result sign differs. SUB is set when the operand signs differ and the result sign differs from A. All other ops clear it.
- Add/sub arithmetic is modulo 2^WIDTH. SLT compares exact signed values, not the sign of a wrapped difference.
- `start` while `Busy`=1 is ignored, with no queueing.
- An MFHI/MFLO accepted on the cycle after a MULTU/DIVU `Done` sees the new HI/LO.

## Timing
- Reset values:
  - `Result`=0, `Zero`=1, `Overflow`=0, `Busy`=0, `Done`=0.
  - HI=0, LO=0, state IDLE, iteration counter 0.
- Reset mid-operation aborts the iteration immediately. HI/LO return to 0 and no `Done` pulse is produced.
- Single-cycle op: `start` sampled at edge k → `Result` valid and `Done`=1 after edge k (one cycle latency), `Done` low after edge k+1 unless another op is accepted at edge k+1.
- Back-to-back single-cycle ops are accepted every cycle, with `Done` held high continuously.
- MULTU/DIVU accepted at edge k:
  - `Busy`=1 after edges k through k+WIDTH-1.
  - HI/LO updated and `Done`=1, `Busy`=0 after edge k+WIDTH.
  - Total latency `WIDTH` cycles.
- A new `start` at edge k+WIDTH (the `Done` cycle) is accepted.
- `Zero` always tracks the currently registered `Result`.

## Test plan
- Reset, then ADD A=0x7FFFFFFF B=1 → Result=0x80000000, Overflow=1, Zero=0, Done one cycle later.
- SUB A=5 B=5 → Result=0, Zero=1, Overflow=0. SLT A=0xFFFFFFFF B=1 → Result=1. NOR A=0 B=0 → 0xFFFFFFFF.
- MULTU A=0xFFFFFFFF B=2:
  - Busy for 32 cycles; a start during Busy is ignored.
  - Done at cycle 32.
  - Then MFHI → 1, MFLO → 0xFFFFFFFE.
- DIVU A=100 B=7 → MFLO=14, MFHI=2. DIVU A=9 B=0 → MFLO=0xFFFFFFFF, MFHI=9.
- Assert rst at iteration 10 of a MULTU → Busy=0, no Done, MFLO then returns 0.
- Undefined Operation 0101 → Result=0, Zero=1, Done pulses. Back-to-back AND/OR on consecutive cycles → results on consecutive cycles.
